gayle_ide_bus: RTL and testbench
================================

Name: gayle_ide_bus

Overview:
CPU-side bus adapter that sits directly upstream of the IDE task-file/buffer controller. It converts Amiga Gayle-style 16-bit CPU bus cycles into single-cycle io_read/io_write strobes on the controller's io port. It stalls the CPU on io_wait/no_data and bounds every stall with a timeout. It also implements the Gayle interrupt status, change, enable and ID registers, and drives the CPU IDE interrupt line.

Parameters:
TIMEOUT, 4095, max cycles a data-register access may stall before forced completion
GAYLE_ID, 8'hD0, value shifted out MSB-first on bit 15 of ID register reads

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
sel_ide  in  1  CPU cycle targets IDE task-file region
sel_gayle  in  1  CPU cycle targets Gayle control region
cpu_addr  in  11  CPU address bits [12:2]
cpu_rd  in  1  read request level, held until cpu_ack seen
cpu_wr  in  1  write request level, held until cpu_ack seen
cpu_din  in  16  CPU write data
cpu_dout  out  16  CPU read data, valid with cpu_ack
cpu_ack  out  1  one-cycle bus cycle completion
cpu_irq  out  1  IDE interrupt to Paula/INT2
io_address  out  4  controller register address
io_read  out  1  controller read strobe
io_write  out  1  controller write strobe
io_writedata  out  32  controller write data
io_32  out  1  constant 0 (16-bit accesses only)
io_readdata  in  32  controller read data, valid cycle after io_read
io_wait  in  1  controller busy; stall data-register access
no_data  in  1  fast-read data not yet available
ide_irq  in  1  controller interrupt level
drive_en  in  2  drive present bits

Behaviour:
- Reset values (rst_n low at clk edge): state IDLE; cpu_ack=0, cpu_dout=0, io_read=0, io_write=0, io_address=0, io_writedata=0; intchg=0, inten=0, id_cnt=0; cpu_irq=0. Reset mid-cycle aborts with no strobe and no ack.
- io_address = {cpu_addr[12], cpu_addr[4:2]}. Offset 0x1018 maps to 14 (alt status), 0x101C to 15.
- Write data: address 0 -> {16'h0, cpu_din}. Other addresses -> {24'h0, cpu_din[15:8]}.
- Read data: address 0 -> io_readdata[15:0]. Others -> {io_readdata[7:0], 8'h00}.
- FSM states: IDLE, HOLD, STROBE, LATCH, ACK, DONE.
- IDLE: on (cpu_rd|cpu_wr) & sel_ide:
  - If address 0 and (io_wait | (cpu_rd & no_data)), go HOLD.
  - Otherwise go STROBE.
  - If both rd and wr are set, rd wins.
- HOLD: stall counter increments each cycle. Leave to STROBE when the stall condition drops. At count==TIMEOUT, skip the strobe and go ACK with cpu_dout=16'hFFFF.
- STROBE: io_read or io_write is high for exactly this one cycle, never two consecutive cycles for one CPU access.
- LATCH (reads only): capture io_readdata into cpu_dout. Writes go straight to ACK.
- ACK: cpu_ack=1 for one cycle.
- DONE: wait for cpu_rd=cpu_wr=0, then IDLE. Guarantees one strobe per CPU cycle.
- Latency, no stall: read ack 3 cycles after request sampled; write ack 2 cycles.
- If drive_en==0, IDE accesses still complete normally; the controller supplies 0xFF reads.
- sel_gayle accesses use IDLE->ACK->DONE, no io strobe. Register index = cpu_addr[12:11].
  - 0, int status: read bit15 = ide_irq. Writes ignored.
  - 1, int change: read bit15 = intchg. Write clears intchg when cpu_din[15]=0, else no change.
  - 2, int enable: read/write bit15 = inten.
  - 3, ID: read bit15 = GAYLE_ID[7-id_cnt], then id_cnt++ (3-bit, wraps). Any write sets id_cnt=0.
  - All other bits read 0.
- intchg is set on the ide_irq rising edge, using a registered previous value. If a rising edge and a CPU clear fall in the same cycle, set wins.
- cpu_irq registered = intchg & inten.
- sel_ide and sel_gayle both set: sel_ide wins.

Test Plan:
- Write 0x20 to offset 0x01C, then read 0x01C with controller status 0x58: exactly one io_write pulse with io_address=7 and io_writedata=0x20; read returns cpu_dout=0x5800 with ack 3 cycles after request.
- Read data register while io_wait=1 for 20 cycles: no io_read during the stall; one io_read pulse after io_wait falls; cpu_dout = io_readdata[15:0] (e.g. 0xA55A).
- no_data held high beyond TIMEOUT=16 (override): ack at stall count 16 with cpu_dout=0xFFFF and zero io_read pulses.
- Pulse ide_irq 0->1 with inten=1: cpu_irq=1 two cycles later. Write 0x0000 to int change: cpu_irq=0. Rising edge in the same cycle as the clear leaves intchg=1.
- Write ID register, then 8 reads: bit15 sequence 1,1,0,1,0,0,0,0; 9th read returns 1.
- Assert rst_n low during HOLD: no strobe, no ack. Outputs at reset values next cycle. A new access after reset completes normally.

Source files
------------

// File: rtl/gayle_ide_bus_if.sv
// CPU-side Gayle bus: request/select/address/data from the CPU, read data
// and completion back from the adapter.
interface gayle_ide_bus_if;
    logic        sel_ide;
    logic        sel_gayle;
    logic [10:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;
    logic        cpu_ack;

    modport master (
        output sel_ide, sel_gayle, cpu_addr, cpu_rd, cpu_wr, cpu_din,
        input  cpu_dout, cpu_ack
    );

    modport slave (
        input  sel_ide, sel_gayle, cpu_addr, cpu_rd, cpu_wr, cpu_din,
        output cpu_dout, cpu_ack
    );
endinterface

// File: rtl/gayle_ide_bus.sv
// Gayle CPU bus to IDE controller io-port adapter: one io strobe per CPU
// cycle, bounded stalls on io_wait/no_data, Gayle interrupt/ID registers.
module gayle_ide_bus #(
    parameter int unsigned TIMEOUT  = 4095,
    parameter logic [7:0]  GAYLE_ID = 8'hD0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gayle_ide_bus_if.slave        cpu,
    output logic                  cpu_irq,
    output logic [3:0]            io_address,
    output logic                  io_read,
    output logic                  io_write,
    output logic [31:0]           io_writedata,
    output logic                  io_32,
    input  logic [31:0]           io_readdata,
    input  logic                  io_wait,
    input  logic                  no_data,
    input  logic                  ide_irq,
    input  logic [1:0]            drive_en
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HOLD   = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_LATCH  = 3'd3;
    localparam logic [2:0] S_ACK    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic          is_rd_q, is_rd_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic [15:0]   cpu_dout_q, cpu_dout_d;
    logic          io_read_q, io_read_d;
    logic          io_write_q, io_write_d;
    logic [3:0]    io_address_q, io_address_d;
    logic [31:0]   io_writedata_q, io_writedata_d;
    logic          intchg_q, intchg_d;
    logic          inten_q, inten_d;
    logic [2:0]    id_cnt_q, id_cnt_d;
    logic          irq_prev_q;
    logic          cpu_irq_q;

    logic          req;
    logic          clr_chg;
    logic [3:0]    ide_addr;
    logic [15:0]   gayle_rdata;

    // Drive presence does not change bus timing; the controller itself
    // returns 0xFF for absent drives.
    logic unused_bits;
    assign unused_bits = ^{drive_en, io_readdata[31:16], cpu.cpu_addr[8:3]};

    assign req      = cpu.cpu_rd | cpu.cpu_wr;
    assign ide_addr = {cpu.cpu_addr[10], cpu.cpu_addr[2:0]};

    // Next-state and output-register logic for the bus-cycle FSM and Gayle registers
    always_comb begin
        state_d        = state_q;
        stall_cnt_d    = stall_cnt_q;
        is_rd_d        = is_rd_q;
        cpu_ack_d      = 1'b0;
        cpu_dout_d     = cpu_dout_q;
        io_read_d      = 1'b0;
        io_write_d     = 1'b0;
        io_address_d   = io_address_q;
        io_writedata_d = io_writedata_q;
        inten_d        = inten_q;
        id_cnt_d       = id_cnt_q;
        clr_chg        = 1'b0;
        gayle_rdata    = '0;
        case (state_q)
            S_IDLE: begin
                if (req && cpu.sel_ide) begin
                    io_address_d   = ide_addr;
                    is_rd_d        = cpu.cpu_rd;
                    io_writedata_d = (ide_addr == 4'd0) ? {16'h0, cpu.cpu_din}
                                                        : {24'h0, cpu.cpu_din[15:8]};
                    if (ide_addr == 4'd0 && (io_wait || (cpu.cpu_rd && no_data))) begin
                        state_d     = S_HOLD;
                        stall_cnt_d = '0;
                    end else begin
                        state_d    = S_STROBE;
                        io_read_d  = cpu.cpu_rd;
                        io_write_d = ~cpu.cpu_rd;
                    end
                end else if (req && cpu.sel_gayle) begin
                    state_d   = S_ACK;
                    cpu_ack_d = 1'b1;
                    case (cpu.cpu_addr[10:9])
                        2'd0: gayle_rdata[15] = ide_irq;
                        2'd1: begin
                            gayle_rdata[15] = intchg_q;
                            if (!cpu.cpu_rd && !cpu.cpu_din[15]) clr_chg = 1'b1;
                        end
                        2'd2: begin
                            gayle_rdata[15] = inten_q;
                            if (!cpu.cpu_rd) inten_d = cpu.cpu_din[15];
                        end
                        default: begin
                            gayle_rdata[15] = GAYLE_ID[3'd7 - id_cnt_q];
                            id_cnt_d = cpu.cpu_rd ? id_cnt_q + 3'd1 : 3'd0;
                        end
                    endcase
                    if (cpu.cpu_rd) cpu_dout_d = gayle_rdata;
                end
            end
            S_HOLD: begin
                if (stall_cnt_q == CW'(TIMEOUT)) begin
                    state_d    = S_ACK;
                    cpu_ack_d  = 1'b1;
                    cpu_dout_d = 16'hFFFF;
                end else if (!(io_wait || (is_rd_q && no_data))) begin
                    state_d    = S_STROBE;
                    io_read_d  = is_rd_q;
                    io_write_d = ~is_rd_q;
                end else begin
                    stall_cnt_d = stall_cnt_q + CW'(1);
                end
            end
            S_STROBE: begin
                state_d   = is_rd_q ? S_LATCH : S_ACK;
                cpu_ack_d = ~is_rd_q;
            end
            S_LATCH: begin
                cpu_dout_d = (io_address_q == 4'd0) ? io_readdata[15:0]
                                                    : {io_readdata[7:0], 8'h00};
                state_d    = S_ACK;
                cpu_ack_d  = 1'b1;
            end
            S_ACK:   state_d = S_DONE;
            S_DONE:  if (!req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Rising edge of ide_irq sets the change flag and takes priority over a CPU clear
    always_comb begin
        if (ide_irq && !irq_prev_q) intchg_d = 1'b1;
        else if (clr_chg)           intchg_d = 1'b0;
        else                        intchg_d = intchg_q;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            stall_cnt_q    <= '0;
            is_rd_q        <= 1'b0;
            cpu_ack_q      <= 1'b0;
            cpu_dout_q     <= '0;
            io_read_q      <= 1'b0;
            io_write_q     <= 1'b0;
            io_address_q   <= '0;
            io_writedata_q <= '0;
            intchg_q       <= 1'b0;
            inten_q        <= 1'b0;
            id_cnt_q       <= '0;
            irq_prev_q     <= 1'b0;
            cpu_irq_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            stall_cnt_q    <= stall_cnt_d;
            is_rd_q        <= is_rd_d;
            cpu_ack_q      <= cpu_ack_d;
            cpu_dout_q     <= cpu_dout_d;
            io_read_q      <= io_read_d;
            io_write_q     <= io_write_d;
            io_address_q   <= io_address_d;
            io_writedata_q <= io_writedata_d;
            intchg_q       <= intchg_d;
            inten_q        <= inten_d;
            id_cnt_q       <= id_cnt_d;
            irq_prev_q     <= ide_irq;
            cpu_irq_q      <= intchg_q & inten_q;
        end
    end

    assign cpu.cpu_ack   = cpu_ack_q;
    assign cpu.cpu_dout  = cpu_dout_q;
    assign cpu_irq       = cpu_irq_q;
    assign io_address    = io_address_q;
    assign io_read       = io_read_q;
    assign io_write      = io_write_q;
    assign io_writedata  = io_writedata_q;
    assign io_32         = 1'b0;
endmodule

// File: tb/tb_gayle_ide_bus.sv
// Self-checking bench for gayle_ide_bus: two instances (default TIMEOUT and
// TIMEOUT=16) see identical CPU/controller stimulus.
module tb_gayle_ide_bus;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] io_readdata = '0;
    logic        io_wait = 1'b0, no_data = 1'b0, ide_irq = 1'b0;
    logic [1:0]  drive_en = 2'b11;

    logic        cpu_irq, io_read, io_write, io_32;
    logic [3:0]  io_address;
    logic [31:0] io_writedata;
    logic        cpu_irq_t, io_read_t, io_write_t, io_32_t;
    logic [3:0]  io_address_t;
    logic [31:0] io_writedata_t;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [35:0] exp_wq[$];

    gayle_ide_bus_if bus();
    gayle_ide_bus_if bus_t();

    assign bus_t.sel_ide   = bus.sel_ide;
    assign bus_t.sel_gayle = bus.sel_gayle;
    assign bus_t.cpu_addr  = bus.cpu_addr;
    assign bus_t.cpu_rd    = bus.cpu_rd;
    assign bus_t.cpu_wr    = bus.cpu_wr;
    assign bus_t.cpu_din   = bus.cpu_din;

    always #5 clk = ~clk;

    gayle_ide_bus dut (
        .clk(clk), .rst_n(rst_n), .cpu(bus), .cpu_irq(cpu_irq),
        .io_address(io_address), .io_read(io_read), .io_write(io_write),
        .io_writedata(io_writedata), .io_32(io_32), .io_readdata(io_readdata),
        .io_wait(io_wait), .no_data(no_data), .ide_irq(ide_irq), .drive_en(drive_en)
    );

    gayle_ide_bus #(.TIMEOUT(16)) dut_t (
        .clk(clk), .rst_n(rst_n), .cpu(bus_t), .cpu_irq(cpu_irq_t),
        .io_address(io_address_t), .io_read(io_read_t), .io_write(io_write_t),
        .io_writedata(io_writedata_t), .io_32(io_32_t), .io_readdata(io_readdata),
        .io_wait(io_wait), .no_data(no_data), .ide_irq(ide_irq), .drive_en(drive_en)
    );

    // One CPU access; cyc = clock edges from request to ack being visible.
    task automatic cpu_access(input bit use_t, input bit s_ide, input bit s_gayle,
                              input logic [10:0] addr, input bit rd, input bit wr,
                              input logic [15:0] din, output int cyc,
                              output logic [15:0] dout, output int nrd, output int nwr,
                              output int nack, output int first_rd,
                              output logic [3:0] st_addr, output logic [31:0] st_wdata);
        bit acked;
        acked = 0; cyc = 0; nrd = 0; nwr = 0; nack = 0; first_rd = -1;
        dout = '0; st_addr = '0; st_wdata = '0;
        bus.sel_ide = s_ide; bus.sel_gayle = s_gayle; bus.cpu_addr = addr;
        bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_din = din;
        for (int i = 0; i < 200 && !acked; i++) begin
            @(negedge clk);
            cyc++;
            if (use_t ? io_read_t : io_read) begin
                nrd++;
                if (first_rd < 0) first_rd = cyc;
                st_addr = use_t ? io_address_t : io_address;
            end
            if (use_t ? io_write_t : io_write) begin
                nwr++;
                st_addr  = use_t ? io_address_t : io_address;
                st_wdata = use_t ? io_writedata_t : io_writedata;
            end
            if (use_t ? bus_t.cpu_ack : bus.cpu_ack) begin
                acked = 1; nack++;
                dout = use_t ? bus_t.cpu_dout : bus.cpu_dout;
            end
        end
        bus.cpu_rd = 0; bus.cpu_wr = 0; bus.sel_ide = 0; bus.sel_gayle = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (use_t ? io_read_t : io_read) nrd++;
            if (use_t ? io_write_t : io_write) nwr++;
            if (use_t ? bus_t.cpu_ack : bus.cpu_ack) nack++;
        end
        if (!acked) nack = -1;
    endtask

    int cyc, nrd, nwr, nack, frd;
    logic [15:0] dout, e16;
    logic [3:0]  sa;
    logic [31:0] sw;
    logic [35:0] e36;

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++; if (bus.cpu_ack !== 1'b0 || bus.cpu_dout !== 16'h0) begin errors++;
            $display("FAIL reset_cpu: ack=%b dout=%h required 0/0000", bus.cpu_ack, bus.cpu_dout); end
        checks++; if (io_read !== 1'b0 || io_write !== 1'b0) begin errors++;
            $display("FAIL reset_strobe: rd=%b wr=%b required 0/0", io_read, io_write); end
        checks++; if (io_address !== 4'h0 || io_writedata !== 32'h0) begin errors++;
            $display("FAIL reset_io: addr=%h wdata=%h required 0/0", io_address, io_writedata); end
        checks++; if (cpu_irq !== 1'b0 || io_32 !== 1'b0) begin errors++;
            $display("FAIL reset_irq_io32: irq=%b io32=%b required 0/0", cpu_irq, io_32); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_taskfile();
        // byte register write on upper lane
        exp_wq.push_back({4'd7, 32'h20});
        cpu_access(0, 1, 0, 11'h007, 0, 1, 16'h2000, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        e36 = exp_wq.pop_front();
        checks++; if ({sa, sw} !== e36) begin errors++;
            $display("FAIL tf_write_data: got %h required %h", {sa, sw}, e36); end
        checks++; if (nwr !== 1 || nrd !== 0 || nack !== 1) begin errors++;
            $display("FAIL tf_write_pulses: wr=%0d rd=%0d ack=%0d required 1/0/1", nwr, nrd, nack); end
        checks++; if (cyc !== 2) begin errors++;
            $display("FAIL tf_write_latency: got %0d required 2", cyc); end
        // status read
        io_readdata = 32'h58;
        exp_q.push_back(16'h5800);
        cpu_access(0, 1, 0, 11'h007, 1, 0, 16'h0, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        e16 = exp_q.pop_front();
        checks++; if (dout !== e16) begin errors++;
            $display("FAIL tf_read_data: got %h required %h", dout, e16); end
        checks++; if (cyc !== 3 || nrd !== 1 || nwr !== 0 || sa !== 4'd7) begin errors++;
            $display("FAIL tf_read_cycle: lat=%0d rd=%0d wr=%0d addr=%0d required 3/1/0/7", cyc, nrd, nwr, sa); end
        // alt status at 0x1018 -> 14
        io_readdata = 32'h50;
        exp_q.push_back(16'h5000);
        cpu_access(0, 1, 0, 11'h406, 1, 0, 16'h0, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        e16 = exp_q.pop_front();
        checks++; if (dout !== e16 || sa !== 4'd14) begin errors++;
            $display("FAIL tf_altstatus: dout=%h addr=%0d required %h/14", dout, sa, e16); end
        // 0x101C -> 15
        exp_wq.push_back({4'd15, 32'h0E});
        cpu_access(0, 1, 0, 11'h407, 0, 1, 16'h0E99, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        e36 = exp_wq.pop_front();
        checks++; if ({sa, sw} !== e36) begin errors++;
            $display("FAIL tf_reg15_write: got %h required %h", {sa, sw}, e36); end
        // data register write: full 16 bits
        exp_wq.push_back({4'd0, 32'h1234});
        cpu_access(0, 1, 0, 11'h000, 0, 1, 16'h1234, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        e36 = exp_wq.pop_front();
        checks++; if ({sa, sw} !== e36 || cyc !== 2) begin errors++;
            $display("FAIL tf_data_write: got %h lat=%0d required %h lat=2", {sa, sw}, cyc, e36); end
        // rd and wr both set: read wins
        cpu_access(0, 1, 0, 11'h007, 1, 1, 16'h0, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        checks++; if (nrd !== 1 || nwr !== 0) begin errors++;
            $display("FAIL tf_rd_wins: rd=%0d wr=%0d required 1/0", nrd, nwr); end
        // both selects: IDE wins
        cpu_access(0, 1, 1, 11'h007, 1, 0, 16'h0, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        checks++; if (nrd !== 1 || cyc !== 3) begin errors++;
            $display("FAIL tf_ide_wins: rd=%0d lat=%0d required 1/3", nrd, cyc); end
        // no drives present still completes
        drive_en = 2'b00; io_readdata = 32'hFF;
        exp_q.push_back(16'hFF00);
        cpu_access(0, 1, 0, 11'h007, 1, 0, 16'h0, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        e16 = exp_q.pop_front();
        checks++; if (dout !== e16 || nack !== 1) begin errors++;
            $display("FAIL tf_no_drive: dout=%h ack=%0d required %h/1", dout, nack, e16); end
        drive_en = 2'b11;
    endtask

    task automatic test_wait();
        io_readdata = 32'h0000A55A; io_wait = 1;
        exp_q.push_back(16'hA55A);
        fork
            cpu_access(0, 1, 0, 11'h000, 1, 0, 16'h0, cyc, dout, nrd, nwr, nack, frd, sa, sw);
            begin repeat (20) @(negedge clk); io_wait = 0; end
        join
        e16 = exp_q.pop_front();
        checks++; if (dout !== e16) begin errors++;
            $display("FAIL wait_data: got %h required %h", dout, e16); end
        checks++; if (nrd !== 1 || frd <= 20) begin errors++;
            $display("FAIL wait_strobe: pulses=%0d first=%0d required 1/>20", nrd, frd); end
        // no_data only stalls reads
        no_data = 1;
        cpu_access(0, 1, 0, 11'h000, 0, 1, 16'hBEEF, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        no_data = 0;
        checks++; if (cyc !== 2 || nwr !== 1 || sw !== 32'hBEEF) begin errors++;
            $display("FAIL nodata_write: lat=%0d wr=%0d wdata=%h required 2/1/0000beef", cyc, nwr, sw); end
    endtask

    task automatic test_irq();
        ide_irq = 0;
        cpu_access(0, 0, 1, 11'h400, 0, 1, 16'h8000, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        checks++; if (cyc !== 1 || nack !== 1 || nrd + nwr !== 0) begin errors++;
            $display("FAIL gayle_latency: lat=%0d ack=%0d strobes=%0d required 1/1/0", cyc, nack, nrd + nwr); end
        exp_q.push_back(16'h8000);
        cpu_access(0, 0, 1, 11'h400, 1, 0, 16'h0, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        e16 = exp_q.pop_front();
        checks++; if (dout !== e16) begin errors++;
            $display("FAIL inten_read: got %h required %h", dout, e16); end
        @(negedge clk); ide_irq = 1;
        @(negedge clk);
        checks++; if (cpu_irq !== 1'b0) begin errors++;
            $display("FAIL irq_early: got %b required 0", cpu_irq); end
        @(negedge clk);
        checks++; if (cpu_irq !== 1'b1) begin errors++;
            $display("FAIL irq_raise: got %b required 1", cpu_irq); end
        exp_q.push_back(16'h8000);
        cpu_access(0, 0, 1, 11'h000, 1, 0, 16'h0, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        e16 = exp_q.pop_front();
        checks++; if (dout !== e16) begin errors++;
            $display("FAIL status_read: got %h required %h", dout, e16); end
        // write with bit15=1 leaves intchg set
        cpu_access(0, 0, 1, 11'h200, 0, 1, 16'h8000, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        exp_q.push_back(16'h8000);
        cpu_access(0, 0, 1, 11'h200, 1, 0, 16'h0, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        e16 = exp_q.pop_front();
        checks++; if (dout !== e16) begin errors++;
            $display("FAIL intchg_keep: got %h required %h", dout, e16); end
        cpu_access(0, 0, 1, 11'h200, 0, 1, 16'h0000, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        @(negedge clk);
        checks++; if (cpu_irq !== 1'b0) begin errors++;
            $display("FAIL irq_clear: got %b required 0", cpu_irq); end
        exp_q.push_back(16'h0000);
        cpu_access(0, 0, 1, 11'h200, 1, 0, 16'h0, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        e16 = exp_q.pop_front();
        checks++; if (dout !== e16) begin errors++;
            $display("FAIL intchg_cleared: got %h required %h", dout, e16); end
        // rising edge in the same cycle as a clear: set wins
        ide_irq = 0;
        repeat (2) @(negedge clk);
        ide_irq = 1;
        cpu_access(0, 0, 1, 11'h200, 0, 1, 16'h0000, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        exp_q.push_back(16'h8000);
        cpu_access(0, 0, 1, 11'h200, 1, 0, 16'h0, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        e16 = exp_q.pop_front();
        checks++; if (dout !== e16) begin errors++;
            $display("FAIL set_wins: got %h required %h", dout, e16); end
        ide_irq = 0;
        exp_q.push_back(16'h0000);
        cpu_access(0, 0, 1, 11'h000, 1, 0, 16'h0, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        e16 = exp_q.pop_front();
        checks++; if (dout !== e16) begin errors++;
            $display("FAIL status_low: got %h required %h", dout, e16); end
    endtask

    task automatic test_id();
        logic [7:0] idv;
        idv = 8'hD0;
        cpu_access(0, 0, 1, 11'h600, 0, 1, 16'h0, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back({idv[7 - (i % 8)], 15'h0});
            cpu_access(0, 0, 1, 11'h600, 1, 0, 16'h0, cyc, dout, nrd, nwr, nack, frd, sa, sw);
            e16 = exp_q.pop_front();
            checks++; if (dout !== e16) begin errors++;
                $display("FAIL id_read_%0d: got %h required %h", i, dout, e16); end
        end
    endtask

    task automatic test_timeout();
        no_data = 1;
        exp_q.push_back(16'hFFFF);
        cpu_access(1, 1, 0, 11'h000, 1, 0, 16'h0, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        e16 = exp_q.pop_front();
        checks++; if (dout !== e16 || nack !== 1) begin errors++;
            $display("FAIL timeout_data: dout=%h ack=%0d required %h/1", dout, nack, e16); end
        checks++; if (nrd !== 0 || cyc !== 18) begin errors++;
            $display("FAIL timeout_cycle: rd=%0d lat=%0d required 0/18", nrd, cyc); end
        no_data = 0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit bad;
        bad = 0;
        io_wait = 1;
        bus.sel_ide = 1; bus.cpu_addr = 11'h000; bus.cpu_rd = 1; bus.cpu_wr = 0;
        repeat (5) begin @(negedge clk); if (io_read || bus.cpu_ack) bad = 1; end
        rst_n = 0;
        repeat (2) begin @(negedge clk); if (io_read || bus.cpu_ack) bad = 1; end
        checks++; if (io_address !== 4'h0 || io_writedata !== 32'h0 || bus.cpu_dout !== 16'h0) begin errors++;
            $display("FAIL rstmid_values: addr=%h wdata=%h dout=%h required 0/0/0", io_address, io_writedata, bus.cpu_dout); end
        bus.cpu_rd = 0; bus.sel_ide = 0; rst_n = 1; io_wait = 0;
        repeat (3) begin @(negedge clk); if (io_read || bus.cpu_ack) bad = 1; end
        checks++; if (bad !== 1'b0) begin errors++;
            $display("FAIL rstmid_quiet: spurious strobe/ack=%b required 0", bad); end
        io_readdata = 32'h1357;
        exp_q.push_back(16'h1357);
        cpu_access(0, 1, 0, 11'h000, 1, 0, 16'h0, cyc, dout, nrd, nwr, nack, frd, sa, sw);
        e16 = exp_q.pop_front();
        checks++; if (dout !== e16 || cyc !== 3 || nrd !== 1) begin errors++;
            $display("FAIL rstmid_after: dout=%h lat=%0d rd=%0d required %h/3/1", dout, cyc, nrd, e16); end
    endtask

    initial begin
        bus.sel_ide = 0; bus.sel_gayle = 0; bus.cpu_addr = '0;
        bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_din = '0;
        test_reset();
        test_taskfile();
        test_wait();
        test_irq();
        test_id();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
